// File: rtl/mem_arbiter_pkg.sv
// Shared memory-bus definitions: command encoding, tag type and arbiter owner IDs.
// Imported by the arbiter top and its tag-ownership table.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef logic [3:0] MEM_TAG_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } ARB_OWNER;

    localparam int unsigned TAG_COUNT = 16;

endpackage

// File: rtl/mem_tag_table.sv
// Outstanding-load ownership table: one {valid, owner} entry per nonzero memory tag.
// One allocate port and one combinational lookup port whose hit can clear the entry at the edge.
module mem_tag_table
    import mem_arbiter_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     alloc_en,
    input  MEM_TAG_t alloc_tag,
    input  ARB_OWNER alloc_owner,
    input  MEM_TAG_t lookup_tag,
    input  logic     clear_en,
    output logic     hit,
    output ARB_OWNER hit_owner
);

    logic [TAG_COUNT-1:0] valid;
    logic [TAG_COUNT-1:0] owner_bits;

    // Tag 0 means "no completion", so entry 0 is never consulted.
    assign hit       = (lookup_tag != '0) && valid[lookup_tag];
    assign hit_owner = ARB_OWNER'(owner_bits[lookup_tag]);

    // NOTE: the allocate write comes after the clear, so when the same tag completes and is
    // re-allocated in one cycle the last non-blocking assignment (the allocation) wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= '0;
        end else begin
            if (clear_en) begin
                valid[lookup_tag] <= 1'b0;
            end
            if (alloc_en) begin
                valid[alloc_tag] <= 1'b1;
            end
        end
    end

    // NOTE: owner bits are not reset; they are only ever read through a set valid bit.
    always_ff @(posedge clock) begin
        if (alloc_en) begin
            owner_bits[alloc_tag] <= alloc_owner;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Icache/Dcache arbiter for the single processor-memory port with starvation guard
// and tag-based routing of load completions back to the issuing cache.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  Icache2mem_command,
    input  logic [31:0] Icache2mem_addr,
    input  logic [1:0]  Dcache2mem_command,
    input  logic [31:0] Dcache2mem_addr,
    input  logic [63:0] Dcache2mem_data,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    output logic [63:0] proc2mem_data,
    output logic [3:0]  mem2Icache_response,
    output logic [3:0]  mem2Dcache_response,
    output logic [63:0] mem2Icache_data,
    output logic [63:0] mem2Dcache_data,
    output logic [3:0]  mem2Icache_tag,
    output logic [3:0]  mem2Dcache_tag,
    output logic        granted_dcache
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       i_req;
    logic       d_req;
    logic       grant_i;
    logic       grant_d;
    logic       accepted;
    logic [3:0] starve_cnt;
    logic [3:0] starve_next;
    logic       alloc_en;
    logic       hit;
    ARB_OWNER   hit_owner;

    // Requests are masked during reset so every output sits at its idle value.
    assign i_req    = !reset && (Icache2mem_command != BUS_NONE);
    assign d_req    = !reset && (Dcache2mem_command != BUS_NONE);
    assign accepted = (mem2proc_response != '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (d_req && (!i_req || starve_cnt != LIMIT)) begin
            grant_d = 1'b1;
        end else if (i_req) begin
            grant_i = 1'b1;
        end
    end

    always_comb begin
        proc2mem_command    = BUS_NONE;
        proc2mem_addr       = '0;
        proc2mem_data       = '0;
        mem2Icache_response = '0;
        mem2Dcache_response = '0;
        if (grant_d) begin
            proc2mem_command    = Dcache2mem_command;
            proc2mem_addr       = Dcache2mem_addr;
            proc2mem_data       = Dcache2mem_data;
            mem2Dcache_response = mem2proc_response;
        end else if (grant_i) begin
            proc2mem_command    = Icache2mem_command;
            proc2mem_addr       = Icache2mem_addr;
            mem2Icache_response = mem2proc_response;
        end
    end

    assign granted_dcache = grant_d;

    // A granted Icache that memory refuses keeps its count, so it stays forced next cycle.
    always_comb begin
        starve_next = starve_cnt;
        if (!i_req) begin
            starve_next = '0;
        end else if (!grant_i) begin
            if (starve_cnt != LIMIT) begin
                starve_next = starve_cnt + 4'd1;
            end
        end else if (accepted) begin
            starve_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_next;
        end
    end

    assign alloc_en = accepted && (proc2mem_command == BUS_LOAD);

    mem_tag_table u_tag_table (
        .clock       (clock),
        .reset       (reset),
        .alloc_en    (alloc_en),
        .alloc_tag   (mem2proc_response),
        .alloc_owner (grant_d ? DCACHE : ICACHE),
        .lookup_tag  (mem2proc_tag),
        .clear_en    (hit && !reset),
        .hit         (hit),
        .hit_owner   (hit_owner)
    );

    assign mem2Icache_data = mem2proc_data;
    assign mem2Dcache_data = mem2proc_data;
    assign mem2Icache_tag  = (!reset && hit && hit_owner == ICACHE) ? mem2proc_tag : '0;
    assign mem2Dcache_tag  = (!reset && hit && hit_owner == DCACHE) ? mem2proc_tag : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reset, forwarding, starvation guard,
// store handling and tag-table routing of load completions.
module tb_mem_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  Icache2mem_command;
    logic [31:0] Icache2mem_addr;
    logic [1:0]  Dcache2mem_command;
    logic [31:0] Dcache2mem_addr;
    logic [63:0] Dcache2mem_data;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2Icache_response;
    logic [3:0]  mem2Dcache_response;
    logic [63:0] mem2Icache_data;
    logic [63:0] mem2Dcache_data;
    logic [3:0]  mem2Icache_tag;
    logic [3:0]  mem2Dcache_tag;
    logic        granted_dcache;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] NONE  = 2'h0;
    localparam logic [1:0] LOAD  = 2'h1;
    localparam logic [1:0] STORE = 2'h2;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .Icache2mem_command  (Icache2mem_command),
        .Icache2mem_addr     (Icache2mem_addr),
        .Dcache2mem_command  (Dcache2mem_command),
        .Dcache2mem_addr     (Dcache2mem_addr),
        .Dcache2mem_data     (Dcache2mem_data),
        .mem2proc_response   (mem2proc_response),
        .mem2proc_data       (mem2proc_data),
        .mem2proc_tag        (mem2proc_tag),
        .proc2mem_command    (proc2mem_command),
        .proc2mem_addr       (proc2mem_addr),
        .proc2mem_data       (proc2mem_data),
        .mem2Icache_response (mem2Icache_response),
        .mem2Dcache_response (mem2Dcache_response),
        .mem2Icache_data     (mem2Icache_data),
        .mem2Dcache_data     (mem2Dcache_data),
        .mem2Icache_tag      (mem2Icache_tag),
        .mem2Dcache_tag      (mem2Dcache_tag),
        .granted_dcache      (granted_dcache)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        Icache2mem_command = NONE;
        Icache2mem_addr    = '0;
        Dcache2mem_command = NONE;
        Dcache2mem_addr    = '0;
        Dcache2mem_data    = '0;
        mem2proc_response  = '0;
        mem2proc_data      = '0;
        mem2proc_tag       = '0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick();

        // Reset with live requests, a response and a tag: outputs must stay idle.
        Icache2mem_command = LOAD;  Icache2mem_addr = 32'h44;
        Dcache2mem_command = LOAD;  Dcache2mem_addr = 32'h88; Dcache2mem_data = 64'h1234;
        mem2proc_response  = 4'd5;  mem2proc_tag = 4'd5;      mem2proc_data = 64'h55;
        settle();
        check("rst_cmd",    proc2mem_command,    NONE);
        check("rst_addr",   proc2mem_addr,       0);
        check("rst_data",   proc2mem_data,       0);
        check("rst_iresp",  mem2Icache_response, 0);
        check("rst_dresp",  mem2Dcache_response, 0);
        check("rst_itag",   mem2Icache_tag,      0);
        check("rst_dtag",   mem2Dcache_tag,      0);
        check("rst_grant",  granted_dcache,      0);
        check("rst_idata",  mem2Icache_data,     64'h55);
        check("rst_ddata",  mem2Dcache_data,     64'h55);
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();

        // Dcache LOAD 0x100 accepted as tag 3; tag 3 returns 5 cycles later with 0xAB.
        Dcache2mem_command = LOAD; Dcache2mem_addr = 32'h100; mem2proc_response = 4'd3;
        settle();
        check("t1_cmd",   proc2mem_command,    LOAD);
        check("t1_addr",  proc2mem_addr,       32'h100);
        check("t1_grant", granted_dcache,      1);
        check("t1_dresp", mem2Dcache_response, 3);
        check("t1_iresp", mem2Icache_response, 0);
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t1_wait_itag", mem2Icache_tag, 0);
            check("t1_wait_dtag", mem2Dcache_tag, 0);
            tick();
        end
        mem2proc_tag = 4'd3; mem2proc_data = 64'hAB;
        settle();
        check("t1_ret_dtag",  mem2Dcache_tag,  3);
        check("t1_ret_itag",  mem2Icache_tag,  0);
        check("t1_ret_ddata", mem2Dcache_data, 64'hAB);
        tick();
        settle();
        check("t1_cleared_dtag", mem2Dcache_tag, 0);
        idle_inputs();
        tick();

        // Both caches request every cycle with memory always accepting: Icache every 5th cycle.
        Icache2mem_command = LOAD; Icache2mem_addr = 32'h400;
        Dcache2mem_command = LOAD; Dcache2mem_addr = 32'h500;
        mem2proc_response  = 4'd1;
        for (int k = 1; k <= 15; k++) begin
            settle();
            check("starve_grant", granted_dcache, (k % 5 == 0) ? 1'b0 : 1'b1);
            check("starve_addr",  proc2mem_addr,  (k % 5 == 0) ? 32'h400 : 32'h500);
            tick();
        end
        // Forced Icache refused by memory stays granted until accepted.
        for (int k = 1; k <= 7; k++) begin
            mem2proc_response = (k == 5) ? 4'd0 : 4'd1;
            settle();
            check("hold_grant", granted_dcache, (k == 5 || k == 6) ? 1'b0 : 1'b1);
            tick();
        end
        idle_inputs();
        tick();

        // Dcache STORE forwarded with data; a stray tag 7 reaches neither cache.
        Dcache2mem_command = STORE; Dcache2mem_addr = 32'h200; Dcache2mem_data = 64'hDEAD;
        mem2proc_response  = 4'd7;
        settle();
        check("st_cmd",   proc2mem_command,    STORE);
        check("st_addr",  proc2mem_addr,       32'h200);
        check("st_data",  proc2mem_data,       64'hDEAD);
        check("st_dresp", mem2Dcache_response, 7);
        tick();
        idle_inputs();
        mem2proc_tag = 4'd7;
        settle();
        check("st_itag", mem2Icache_tag, 0);
        check("st_dtag", mem2Dcache_tag, 0);
        tick();

        // Icache load as tag 2, Dcache load as tag 9; returns in order 9 then 2.
        idle_inputs();
        Icache2mem_command = LOAD; Icache2mem_addr = 32'h300;
        Dcache2mem_data    = 64'hFFFF; mem2proc_response = 4'd2;
        settle();
        check("il_grant", granted_dcache,      0);
        check("il_data",  proc2mem_data,       0);
        check("il_iresp", mem2Icache_response, 2);
        check("il_dresp", mem2Dcache_response, 0);
        tick();
        idle_inputs();
        Dcache2mem_command = LOAD; Dcache2mem_addr = 32'h600; mem2proc_response = 4'd9;
        settle();
        check("dl_dresp", mem2Dcache_response, 9);
        tick();
        idle_inputs();
        mem2proc_tag = 4'd9;
        settle();
        check("r9_dtag", mem2Dcache_tag, 9);
        check("r9_itag", mem2Icache_tag, 0);
        tick();
        mem2proc_tag = 4'd2;
        settle();
        check("r2_itag", mem2Icache_tag, 2);
        check("r2_dtag", mem2Dcache_tag, 0);
        tick();
        mem2proc_tag = 4'd9;
        settle();
        check("r9_again_dtag", mem2Dcache_tag, 0);
        tick();
        mem2proc_tag = 4'd2;
        settle();
        check("r2_again_itag", mem2Icache_tag, 0);
        tick();

        // Tag 4 completes for Icache while a Dcache load reuses tag 4 in the same cycle.
        idle_inputs();
        Icache2mem_command = LOAD; Icache2mem_addr = 32'h700; mem2proc_response = 4'd4;
        tick();
        idle_inputs();
        Dcache2mem_command = LOAD; Dcache2mem_addr = 32'h800; mem2proc_response = 4'd4;
        mem2proc_tag = 4'd4;
        settle();
        check("same_itag",  mem2Icache_tag,      4);
        check("same_dtag",  mem2Dcache_tag,      0);
        check("same_dresp", mem2Dcache_response, 4);
        tick();
        idle_inputs();
        mem2proc_tag = 4'd4;
        settle();
        check("next4_dtag", mem2Dcache_tag, 4);
        check("next4_itag", mem2Icache_tag, 0);
        tick();

        // Icache load outstanding as tag 6 is dropped by a one-cycle reset.
        idle_inputs();
        Icache2mem_command = LOAD; Icache2mem_addr = 32'h900; mem2proc_response = 4'd6;
        settle();
        check("pre_rst_iresp", mem2Icache_response, 6);
        tick();
        reset = 1'b1;
        Dcache2mem_command = LOAD; Dcache2mem_addr = 32'hA00; mem2proc_tag = 4'd6;
        settle();
        check("mid_rst_cmd",   proc2mem_command,    NONE);
        check("mid_rst_iresp", mem2Icache_response, 0);
        check("mid_rst_dresp", mem2Dcache_response, 0);
        check("mid_rst_itag",  mem2Icache_tag,      0);
        check("mid_rst_grant", granted_dcache,      0);
        tick();
        reset = 1'b0;
        idle_inputs();
        mem2proc_tag = 4'd6;
        settle();
        check("post_rst_itag", mem2Icache_tag, 0);
        check("post_rst_dtag", mem2Dcache_tag, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single processor–memory port between the instruction cache and the data cache. Each cycle it selects one requester, forwards that requester's command to memory, and returns the memory's same-cycle accept response only to the granted cache. A registered tag-ownership table routes each later load completion (returned tag plus data) to the cache that issued it. The block sits between both caches and the memory model, replacing any direct cache-to-memory wiring.

## Interface
- STARVE_LIMIT, 4: maximum number of consecutive cycles an Icache request may be denied before Icache is forced onto the bus. Legal range is 1–15.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- Icache2mem_command  in  2  BUS_NONE or BUS_LOAD
- Icache2mem_addr  in  32  Icache request address
- Dcache2mem_command  in  2  BUS_NONE, BUS_LOAD or BUS_STORE
- Dcache2mem_addr  in  32  Dcache request address
- Dcache2mem_data  in  64  Dcache store data
- mem2proc_response  in  4  memory accept tag; 0 means not accepted
- mem2proc_data  in  64  returned load data
- mem2proc_tag  in  4  completion tag; 0 means no completion
- proc2mem_command  out  2  forwarded command
- proc2mem_addr  out  32  forwarded address
- proc2mem_data  out  64  forwarded store data
- mem2Icache_response / mem2Dcache_response  out  4 each  gated accept tag
- mem2Icache_data / mem2Dcache_data  out  64 each  mem2proc_data, ungated
- mem2Icache_tag / mem2Dcache_tag  out  4 each  gated completion tag
- granted_dcache  out  1  high when Dcache owns the bus this cycle

## Operation
- Grant (combinational):
  - Only Dcache requests → Dcache.
  - Only Icache requests → Icache.
  - Both request → Dcache, unless starve_cnt == STARVE_LIMIT; in that case Icache.
  - Neither requests → drive BUS_NONE, address 0, data 0. granted_dcache = 0.
- Forwarding: the granted cache's command, address and data go to proc2mem_*. When Icache is granted, proc2mem_data = 0.
- Accept routing:
  - The granted cache's response output = mem2proc_response.
  - The other cache's response output = 0.
- Starvation counter (starve_cnt, 4-bit, saturating at STARVE_LIMIT):
  - Increments when Icache requests and is not granted.
  - Clears when Icache is granted and mem2proc_response != 0, or when Icache is not requesting.
  - Holds when Icache is granted but memory does not accept.
- Tag table, entries 1..15, each holding {valid, owner}:
  - Allocate: on an accepted BUS_LOAD, set entry[response] to {1, granted_dcache}.
  - Stores are never allocated.
- Completion: when mem2proc_tag != 0 and entry[tag].valid:
  - Drive the tag onto the owner's tag output; the other cache's tag output is 0.
  - Clear the entry at the clock edge.
- Unknown tag (entry not valid): both tag outputs are 0 and the completion is dropped.
- Same tag completing and being allocated in the same cycle: the completion routes using the old entry; the allocation write takes effect at the edge.
- Reset (including mid-operation): table cleared, starve_cnt = 0. Completions for loads issued before reset are dropped.

## Timing
- Reset values:
  - proc2mem_command = BUS_NONE; address and data 0.
  - All response and tag outputs 0; granted_dcache 0.
  - Data outputs equal mem2proc_data (pass-through).
- Grant, forwarding and accept routing are all combinational; zero added latency.
- Completion routing is combinational from registered table state.
  - Memory returns a tag no earlier than the cycle after acceptance, so the table entry is always registered before it is used.
- Requesters must hold command, address and data until they see a nonzero response. The arbiter does not latch requests.
- Grant may change every cycle. There is no lock between an issue and its completion.

## Structure
- The BUS_* command encoding and a MEM_TAG_t (4-bit) typedef come from the shared sys_defs header. An ARB_OWNER enum (ICACHE = 0, DCACHE = 1) is added there.
- One sub-module, mem_tag_table: 15-entry valid/owner array with one allocate port, one lookup/clear port and synchronous reset.
- Grant logic and the starvation counter live in the top module.

## Test plan
- Dcache LOAD 0x100 alone; memory responds 3, and tag 3 returns 5 cycles later with data 0xAB → mem2Dcache_response = 3. mem2Dcache_tag = 3 on the return cycle; mem2Icache_tag = 0 throughout.
- Icache and Dcache both request every cycle, memory always accepting, STARVE_LIMIT = 4 → Icache is granted on cycle 5, then every 5th cycle. starve_cnt never exceeds 4.
- Dcache STORE 0x200, data 0xDEAD; memory responds 7, then a stray tag 7 returns → the store is forwarded with its data. The tag 7 completion reaches neither cache.
- Interleaved Icache load accepted as tag 2 and Dcache load accepted as tag 9; tags return in order 9, 2 → 9 goes to Dcache only, 2 goes to Icache only, and both entries are cleared afterwards.
- Tag 4 completes for Icache while a Dcache load is accepted with response 4 in the same cycle → completion goes to Icache. The next return of tag 4 goes to Dcache.
- Icache load outstanding as tag 6, reset asserted for one cycle, then tag 6 returns → both tag outputs are 0, and all outputs hold their reset values during reset.
